result_display8bit: RTL and testbench

Output-side consumer for the calculator's 8-bit result path. The logic/arithmetic units produce an 8-bit result. This block accepts that result through a valid/ready handshake, latches it, and drives a two-digit multiplexed common-anode 7-segment display in hexadecimal. A settle state guarantees that each accepted value is shown on both digits for at least one full scan before a new value is taken, so a digit never flickers between old and new results.

---
 rtl/result_display8bit_pkg.sv | 21 ++
 rtl/result_display8bit_hex_to_seg7.sv | 14 +
 rtl/result_display8bit.sv | 113 +++++++++++
 tb/tb_result_display8bit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_display8bit_pkg.sv
// rtl/result_display8bit_pkg.sv - shared calculator display types and glyph table
package result_display8bit_pkg;

    // Handshake state: IDLE accepts a result, SETTLE holds it until both digits were shown
    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, {g,f,e,d,c,b,a}, active-low; b and d are lowercase
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/result_display8bit_hex_to_seg7.sv
// rtl/result_display8bit_hex_to_seg7.sv - combinational hex nibble to active-low 7-segment glyph
module hex_to_seg7
    import result_display8bit_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup into the shared glyph ROM
    always_comb begin
        seg_o = HEX_SEG[hex_i];
    end

endmodule

// File: rtl/result_display8bit.sv
// rtl/result_display8bit.sv - latches an 8-bit result and scans it onto two hex digits
module result_display8bit
    import result_display8bit_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    output logic       result_ready,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             digit_q;      // digit loaded at the next wrap
    state_t           state_q;
    logic             settle_wrap_q; // one qualifying wrap already seen in SETTLE
    logic [7:0]       disp_q;
    logic             ready_q;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;

    logic             wrap;
    logic             accept;
    logic [3:0]       nibble;
    logic             blank_d;
    logic [6:0]       glyph;

    assign wrap    = (cnt_q == CNT_LAST);
    assign accept  = result_valid & ready_q;
    assign nibble  = digit_q ? disp_q[7:4] : disp_q[3:0];
    assign blank_d = digit_q & blank_lz & (disp_q[7:4] == 4'h0);

    hex_to_seg7 u_hex (
        .hex_i (nibble),
        .seg_o (glyph)
    );

    // Slot timer: wraps every REFRESH_DIV cycles and flips the digit to be loaded next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= 1'b0;
        end else if (wrap) begin
            cnt_q   <= '0;
            digit_q <= ~digit_q;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Output registers reload only on a wrap; the old disp_q is used if an accept coincides
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= 2'b11;
        end else if (wrap) begin
            if (blank_d) begin
                seg_q <= SEG_OFF;
                an_q  <= 2'b11;
            end else begin
                seg_q <= glyph;
                an_q  <= digit_q ? 2'b01 : 2'b10;
            end
        end
    end

    // Handshake FSM: take a result, then refuse new ones until two later wraps have shown it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            disp_q        <= 8'h00;
            settle_wrap_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        disp_q        <= result_in;
                        ready_q       <= 1'b0;
                        settle_wrap_q <= 1'b0;
                        state_q       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (wrap) begin
                        if (settle_wrap_q) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            settle_wrap_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign result_ready = ready_q;
    assign seg          = seg_q;
    assign an           = an_q;

endmodule

// File: tb/tb_result_display8bit.sv
// tb/tb_result_display8bit.sv - randomized and directed bench against a timeline reference model
module tb_result_display8bit;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] result_in;
    logic       result_valid;
    logic       result_ready;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: edges since reset release, wraps seen, displayed byte and expected outputs
    int         m_edges;
    int         m_wraps;
    int         m_settle;
    logic [7:0] m_disp;
    logic       m_ready;
    logic [6:0] m_seg;
    logic [1:0] m_an;
    logic       last_acc;

    always #5 clk = ~clk;

    result_display8bit #(.REFRESH_DIV(DIV)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .result_in    (result_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .blank_lz     (blank_lz),
        .seg          (seg),
        .an           (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_edges  = 0;
        m_wraps  = 0;
        m_settle = 0;
        m_disp   = 8'h00;
        m_ready  = 1'b1;
        m_seg    = 7'h7F;
        m_an     = 2'b11;
        last_acc = 1'b0;
    endtask

    // What the next clock edge does, given the inputs presented for it
    task automatic model_step(input logic v, input logic [7:0] d, input logic b);
        logic is_wrap;
        is_wrap  = (m_edges % DIV) == (DIV - 1);
        last_acc = v && m_ready;
        if (is_wrap) begin
            if ((m_wraps % 2) == 0) begin
                m_an  = 2'b10;
                m_seg = glyph(m_disp[3:0]);
            end else if (b && m_disp[7:4] == 4'h0) begin
                m_an  = 2'b11;
                m_seg = 7'h7F;
            end else begin
                m_an  = 2'b01;
                m_seg = glyph(m_disp[7:4]);
            end
            m_wraps++;
        end
        if (last_acc) begin
            m_disp   = d;
            m_ready  = 1'b0;
            m_settle = 0;
        end else if (!m_ready && is_wrap) begin
            m_settle++;
            if (m_settle == 2) m_ready = 1'b1;
        end
        m_edges++;
    endtask

    // One clock: drive at negedge, advance model, compare at the following negedge
    task automatic tick(input logic v, input logic [7:0] d, input logic b);
        result_valid = v;
        result_in    = d;
        blank_lz     = b;
        model_step(v, d, b);
        @(posedge clk);
        @(negedge clk);
        check("ready", result_ready, m_ready);
        check("seg",   seg,          m_seg);
        check("an",    an,           m_an);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_seg",   seg,            7'h7F);
        check("rst_an",    an,             2'b11);
        check("rst_ready", result_ready,   1'b1);
        check("rst_disp",  u_dut.disp_q,   8'h00);
        @(negedge clk);
        model_reset();
        result_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic b);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 4 * DIV && !done; i++) begin
            tick(1'b1, d, b);
            done = last_acc;
        end
        result_valid = 1'b0;
        check("send_accepted", done, 1'b1);
    endtask

    task automatic wait_ready(input logic b);
        for (int i = 0; i < 4 * DIV && !result_ready; i++) tick(1'b0, 8'h00, b);
        check("wait_ready", result_ready, 1'b1);
    endtask

    task automatic wait_an(input logic [1:0] a, input logic b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * DIV && !hit; i++) begin
            tick(1'b0, 8'h00, b);
            hit = (an === a);
        end
        check("wait_an", an, a);
    endtask

    initial begin
        logic       pending;
        logic [7:0] pdata;

        reset        = 1'b1;
        result_valid = 1'b0;
        result_in    = 8'h00;
        blank_lz     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // First lit digit after release, then a mid-frame reset
        for (int i = 0; i < DIV; i++) tick(1'b0, 8'h00, 1'b0);
        check("first_wrap_an",  an,  2'b10);
        check("first_wrap_seg", seg, 7'h40);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        do_reset();

        // Basic display
        send(8'h3A, 1'b0);
        wait_ready(1'b0);
        wait_an(2'b10, 1'b0);
        check("basic_lo", seg, 7'h08);
        wait_an(2'b01, 1'b0);
        check("basic_hi", seg, 7'h30);

        // Back-pressure: 8'h51 held while FF settles
        send(8'hFF, 1'b0);
        pending = 1'b1;
        for (int i = 0; i < 4 * DIV && pending; i++) begin
            tick(1'b1, 8'h51, 1'b0);
            if (last_acc) pending = 1'b0;
        end
        result_valid = 1'b0;
        check("bp_accepted", pending, 1'b0);
        wait_ready(1'b0);
        wait_an(2'b10, 1'b0);
        check("bp_lo", seg, 7'h79);
        wait_an(2'b01, 1'b0);
        check("bp_hi", seg, 7'h12);

        // Leading-zero blanking
        send(8'h08, 1'b1);
        wait_ready(1'b1);
        wait_an(2'b10, 1'b1);
        check("lz_lo_on", seg, 7'h00);
        wait_an(2'b11, 1'b1);
        check("lz_hi_on", seg, 7'h7F);
        wait_an(2'b10, 1'b0);
        check("lz_lo_off", seg, 7'h00);
        wait_an(2'b01, 1'b0);
        check("lz_hi_off", seg, 7'h40);

        // Accept coinciding with a wrap
        wait_ready(1'b0);
        for (int i = 0; i < DIV && (m_edges % DIV) != (DIV - 1); i++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'hC5, 1'b0);
        result_valid = 1'b0;
        check("wrap_acc", last_acc, 1'b1);
        wait_ready(1'b0);

        // Reset two cycles into SETTLE, then a normal accept
        send(8'h77, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        do_reset();
        send(8'h24, 1'b0);
        wait_ready(1'b0);

        // Randomized traffic with a producer that holds data until accepted
        pending = 1'b0;
        pdata   = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                pending = 1'b0;
            end
            if (!pending && $urandom_range(0, 3) == 0) begin
                pending = 1'b1;
                pdata   = 8'($urandom);
                if ($urandom_range(0, 2) == 0) pdata[7:4] = 4'h0;
            end
            tick(pending, pdata, 1'($urandom_range(0, 1)));
            if (last_acc) pending = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
